// File: rtl/ifid_pkg.sv
// Shared IF/ID queue types: entry bundle and bubble constant.
// word_t is WORD_W bits; ifid_entry_t packs {pcplus4, instr, next_pc}.
package ifid_pkg;

   localparam int WORD_W = 32;

   typedef logic [WORD_W-1:0] word_t;

   typedef struct packed {
      word_t pcplus4;
      word_t instr;
      word_t next_pc;
   } ifid_entry_t;

   localparam ifid_entry_t IFID_BUBBLE = '0;

endpackage

// File: rtl/ifid_queue_if.sv
// Fetch/decode handshake bundle around the IF/ID queue.
// Modports: ifid (queue), fetch (producer), decode (consumer).
interface ifid_queue_if
   import ifid_pkg::*;
#(
   parameter int CNT_W = 3
) (
   input logic CLK,
   input logic nRST
);

   logic             flush;
   logic             push;
   logic             full;
   ifid_entry_t      wdata;
   logic             pop;
   logic             empty;
   ifid_entry_t      rdata;
   logic [CNT_W-1:0] count;

   modport ifid (
      input  CLK, nRST, flush, push, wdata, pop,
      output full, empty, rdata, count
   );

   modport fetch (
      input  CLK, nRST, full, flush,
      output push, wdata
   );

   modport decode (
      input  CLK, nRST, empty, rdata, count,
      output pop, flush
   );

endinterface

// File: rtl/ifid_queue.sv
// DEPTH-entry circular IF/ID FIFO; bubble (all zero) on outputs when empty.
// Ports: CLK, nRST (sync, active low), flush, push/full + *_in,
// pop/empty + *_out, count. IFID_STATS_EN adds stall_cycles, flush_count.
module ifid_queue
   import ifid_pkg::*;
#(
   parameter int WORD_W = ifid_pkg::WORD_W,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              flush,
   input  logic              push,
   output logic              full,
   input  logic [WORD_W-1:0] pcplus4_in,
   input  logic [WORD_W-1:0] instr_in,
   input  logic [WORD_W-1:0] next_pc_in,
   input  logic              pop,
   output logic              empty,
   output logic [WORD_W-1:0] pcplus4_out,
   output logic [WORD_W-1:0] instr_out,
   output logic [WORD_W-1:0] next_pc_out,
`ifdef IFID_STATS_EN
   output logic [31:0]       stall_cycles,
   output logic [31:0]       flush_count,
`endif
   output logic [CNT_W-1:0]  count
);

   localparam int PTR_W = CNT_W - 1;

   ifid_entry_t      mem [DEPTH];
   ifid_entry_t      head;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] cnt;
   logic             do_push;
   logic             do_pop;

   // full/empty come from registered count only
   assign full    = (cnt == CNT_W'(DEPTH));
   assign empty   = (cnt == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign count   = cnt;

   always_ff @(posedge CLK) begin
      if (!nRST || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= IFID_BUBBLE;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= '{pcplus4: pcplus4_in,
                             instr:   instr_in,
                             next_pc: next_pc_in};
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (do_pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         unique case ({do_push, do_pop})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // popped slots keep stale data, so gate the head when empty
   assign head        = empty ? IFID_BUBBLE : mem[rd_ptr];
   assign pcplus4_out = head.pcplus4;
   assign instr_out   = head.instr;
   assign next_pc_out = head.next_pc;

`ifdef IFID_STATS_EN
   logic [31:0] stall_q;
   logic [31:0] flush_q;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (push && full && stall_q != '1)
            stall_q <= stall_q + 32'd1;
         if (flush && flush_q != '1)
            flush_q <= flush_q + 32'd1;
      end
   end

   assign stall_cycles = stall_q;
   assign flush_count  = flush_q;
`endif

endmodule

// File: tb/tb_ifid_queue.sv
// Scoreboard bench for ifid_queue: stimulus queues expected entries,
// a negedge monitor checks the head whenever decode pops.
module tb_ifid_queue;
   import ifid_pkg::*;

   localparam int W  = 32;
   localparam int D  = 4;
   localparam int CW = 3;

   logic          CLK = 1'b0;
   logic          nRST = 1'b0;
   logic          flush = 1'b0;
   logic          push = 1'b0;
   logic          pop = 1'b0;
   logic          full;
   logic          empty;
   logic [W-1:0]  pcplus4_in = '0;
   logic [W-1:0]  instr_in = '0;
   logic [W-1:0]  next_pc_in = '0;
   logic [W-1:0]  pcplus4_out;
   logic [W-1:0]  instr_out;
   logic [W-1:0]  next_pc_out;
   logic [CW-1:0] count;
`ifdef IFID_STATS_EN
   logic [31:0]   stall_cycles;
   logic [31:0]   flush_count;
`endif

   int            total = 0;
   int            bad = 0;
   int            mcnt = 0;
   ifid_entry_t   sb[$];
   ifid_entry_t   e;

   ifid_queue #(.WORD_W(W), .DEPTH(D), .CNT_W(CW)) dut (
      .CLK(CLK), .nRST(nRST), .flush(flush),
      .push(push), .full(full),
      .pcplus4_in(pcplus4_in), .instr_in(instr_in),
      .next_pc_in(next_pc_in),
      .pop(pop), .empty(empty),
      .pcplus4_out(pcplus4_out), .instr_out(instr_out),
      .next_pc_out(next_pc_out),
`ifdef IFID_STATS_EN
      .stall_cycles(stall_cycles), .flush_count(flush_count),
`endif
      .count(count)
   );

   always #5 CLK = ~CLK;

   task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   // Monitor: a pop seen before the edge must present the oldest entry,
   // or a bubble if the model says the queue is empty.
   always @(negedge CLK) begin
      if (nRST && !flush && pop) begin
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("head_pcplus4", pcplus4_out, e.pcplus4);
            chk("head_instr", instr_out, e.instr);
            chk("head_next_pc", next_pc_out, e.next_pc);
            chk("head_valid", {31'd0, empty}, 32'd0);
         end else begin
            chk("bubble_instr", instr_out, 32'd0);
            chk("bubble_pc", pcplus4_out, 32'd0);
            chk("bubble_empty", {31'd0, empty}, 32'd1);
         end
      end
   end

   // One clock: drive, take the edge, update the model, check status.
   task automatic cyc(logic f, logic p, logic [31:0] d, logic q);
      logic acc_push;
      logic acc_pop;
      flush      = f;
      push       = p;
      pop        = q;
      instr_in   = d;
      pcplus4_in = 32'h1000 + d;
      next_pc_in = 32'h2000 + d;
      @(posedge CLK);
      if (!nRST || f) begin
         mcnt = 0;
         sb.delete();
      end else begin
         acc_push = p && (mcnt < D);
         acc_pop  = q && (mcnt > 0);
         if (acc_push) begin
            sb.push_back('{pcplus4: 32'h1000 + d,
                           instr:   d,
                           next_pc: 32'h2000 + d});
            mcnt++;
         end
         if (acc_pop)
            mcnt--;
      end
      #1;
      chk("count", {29'd0, count}, mcnt);
      chk("empty", {31'd0, empty}, {31'd0, mcnt == 0});
      chk("full", {31'd0, full}, {31'd0, mcnt == D});
   endtask

   initial begin
      // 1: reset held with push asserted
      nRST = 1'b0;
      cyc(0, 1, 32'h99, 0);
      cyc(0, 1, 32'h99, 0);
      chk("rst_instr", instr_out, 32'd0);
      nRST = 1'b1;

      // 2: fill, reject extra, drain, pop on empty
      for (int i = 1; i <= 4; i++)
         cyc(0, 1, 32'h11 * i, 0);
      chk("fill_full", {31'd0, full}, 32'd1);
      cyc(0, 1, 32'h55, 0);
      for (int i = 0; i < 4; i++)
         cyc(0, 0, 0, 1);
      chk("drain_instr", instr_out, 32'd0);
      cyc(0, 0, 0, 1);

      // 3: wrap-around with count held at 1
      cyc(0, 1, 32'h100, 0);
      for (int i = 1; i <= 10; i++)
         cyc(0, 1, 32'h100 + i, 1);
      cyc(0, 0, 0, 1);

      // 4: flush with push and pop in the same cycle
      for (int i = 1; i <= 3; i++)
         cyc(0, 1, 32'h200 + i, 0);
      cyc(1, 1, 32'hAA, 1);
      chk("flush_instr", instr_out, 32'd0);
      cyc(0, 0, 0, 1);
      cyc(0, 1, 32'h204, 0);
      cyc(0, 0, 0, 1);

      // 5: full with push+pop, then pop on empty
      for (int i = 1; i <= 4; i++)
         cyc(0, 1, 32'h300 + i, 0);
      cyc(0, 1, 32'h305, 1);
      chk("fullpp_head", instr_out, 32'h302);
      for (int i = 0; i < 3; i++)
         cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
      cyc(0, 1, 32'h306, 0);
      cyc(0, 0, 0, 1);

`ifdef IFID_STATS_EN
      // 6: stall and flush counters
      nRST = 1'b0;
      cyc(0, 0, 0, 0);
      nRST = 1'b1;
      for (int i = 1; i <= 4; i++)
         cyc(0, 1, 32'h400 + i, 0);
      for (int i = 0; i < 5; i++)
         cyc(0, 1, 32'h4FF, 0);
      chk("stall_cycles", stall_cycles, 32'd5);
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      chk("flush_count", flush_count, 32'd2);
      chk("stall_kept", stall_cycles, 32'd5);
      cyc(0, 0, 0, 0);
      chk("flush_hold", flush_count, 32'd2);
      nRST = 1'b0;
      cyc(0, 0, 0, 0);
      nRST = 1'b1;
      chk("stall_rst", stall_cycles, 32'd0);
      chk("flush_rst", flush_count, 32'd0);
`endif

      chk("sb_drained", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
